prbs7_checker: RTL
==================

# prbs7_checker

Receive-side PRBS7 checker for the serdes link test. It consumes parallel words recovered by the deserializer in the stimulus path and decides whether the link is locked. It produces the received-word count and bit-error count that the 7-segment display logic shows. The checker is self-synchronising: each received bit is predicted from the 7 bits before it, so no seed exchange with the transmitter is needed.

## Interface
- W, 4, data word width in bits (serdes ratio); legal 2..16.
- LOCK_CNT, 16, consecutive error-free checkable words required to enter LOCKED; legal 1..255.
- UNLOCK_CNT, 4, consecutive errored words in LOCKED that force return to HUNT; legal 1..255.

- CLK  in  1  parallel-domain clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- CLR  in  1  synchronous clear (from button control); priority over VALID.
- VALID  in  1  DATA carries a new word this cycle.
- DATA  in  W  received word; DATA[W-1] is the earliest bit on the wire.
- LOCKED  out  1  checker is in LOCKED state.
- RECV_CNT  out  58  words received while LOCKED; saturates at all-ones.
- ERR_CNT  out  64  bit mismatches while LOCKED; saturates at all-ones.

## Operation
- History: 7-bit shift register h of the most recent received bits; h[0] is the newest. Each bit is processed in wire order (DATA[W-1] first).
- Prediction for bit b[n]: e[n] = b[n-7] XOR b[n-6]. This is PRBS7, x^7+x^6+1. The mismatch is m[n] = b[n] XOR e[n]. The prediction uses history updated with the earlier bits of the same word.
- Fill counter: counts received bits and saturates at 7. A word is checkable only if fill = 7 at the start of that word. With W=4, words 0 and 1 after reset or CLR are not checkable.
- Word error count: errs = popcount(m) over all W bits, 0..W. A word is errored when errs > 0.
- States:
  - HUNT: a good-word counter g increments on each checkable error-free word and resets to 0 on an errored word. When g reaches LOCK_CNT, the state goes to LOCKED and g is cleared.
  - LOCKED: a bad-word counter u increments on each errored word and resets to 0 on a clean word. When u reaches UNLOCK_CNT, the state goes to HUNT and u is cleared.
- Counting rule: a word is counted only if the state before that word's update is LOCKED.
  - RECV_CNT increments by 1 for each counted word.
  - ERR_CNT increments by errs for each counted word.
  - The word that causes LOCKED→HUNT is still counted.
  - The word that causes HUNT→LOCKED is not counted.
- Saturation: ERR_CNT is clamped to 2^64-1 if the addition would overflow; RECV_CNT holds at 2^58-1. Neither counter ever wraps.
- A single flipped line bit in a locked stream yields exactly 3 mismatches: the flipped bit itself, then the predictions at n+6 and n+7.
- VALID low: no state, history, fill or counter change.
- CLR: clears history, fill, g, u, both counters, and sets state HUNT. When CLR and VALID are asserted together, the word is discarded.
- RST: same values as CLR, applied asynchronously.

## Timing
- Reset values: LOCKED=0, RECV_CNT=0, ERR_CNT=0; internal state HUNT with h, fill, g and u all 0.
- All outputs are registered. A word sampled at edge k is reflected in LOCKED and the counters immediately after edge k, so latency is 1 cycle.
- Back-to-back VALID every cycle must be sustained with no stall; there is no backpressure.
- The mismatch vector, popcount and add may be pipelined by one extra stage only if output latency stays 1 cycle. Otherwise compute them in a single cycle.
- CLR takes effect at the edge it is sampled; outputs are zero after that edge.

## Test plan
- Clean PRBS7 stream, W=4, LOCK_CNT=16, VALID every cycle from reset:
  - LOCKED rises after the edge sampling word index 17.
  - RECV_CNT=1 after word 18, with ERR_CNT=0.
  - After word 1017, RECV_CNT=1000.
- Locked stream, invert one bit in word 100 → ERR_CNT=3 within 3 words; RECV_CNT keeps counting; LOCKED stays 1.
- Locked stream replaced by all-ones data, UNLOCK_CNT=4 → LOCKED falls after the 4th errored word. ERR_CNT equals the mismatches of those 4 words. RECV_CNT increases by exactly 4.
- Locked stream, VALID toggled with random gaps → counts equal the number of VALID words. Idle cycles change nothing, and the PRBS remains error-free across gaps.
- CLR pulsed while locked with VALID high → all outputs 0 the next cycle. Relock occurs after 2 fill words plus LOCK_CNT clean words. RST asserted mid-word gives the same result asynchronously.
- Force RECV_CNT to 2^58-2 and ERR_CNT to 2^64-2 (via hierarchical deposit), then feed 3 errored words → both counters hold at all-ones with no wrap.

Source files
------------

// File: rtl/prbs7_checker.sv
// rtl/prbs7_checker.sv - self-synchronising PRBS7 (x^7+x^6+1) receive checker
// Lock FSM plus saturating word and bit-error counters.
module prbs7_checker #(
  parameter int W          = 4,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CLR,
  input  logic         VALID,
  input  logic [W-1:0] DATA,
  output logic         LOCKED,
  output logic [57:0]  RECV_CNT,
  output logic [63:0]  ERR_CNT
);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam int         EW        = $clog2(W + 1);
  localparam logic [7:0] G_LAST    = 8'(LOCK_CNT - 1);
  localparam logic [7:0] U_LAST    = 8'(UNLOCK_CNT - 1);

  logic [0:0]    state;
  logic [6:0]    h;
  logic [6:0]    h_nxt;
  logic [2:0]    fill;
  logic [2:0]    fill_nxt;
  logic [7:0]    g;
  logic [7:0]    u;
  logic [EW-1:0] errs;
  logic          checkable;
  logic          word_err;
  logic [57:0]   recv_cnt;
  logic [63:0]   err_cnt;
  logic [64:0]   err_sum;

  // Walk the word in wire order; each bit is predicted from history that
  // already includes the earlier bits of the same word.
  always_comb begin
    h_nxt    = h;
    fill_nxt = fill;
    errs     = '0;
    for (int i = W - 1; i >= 0; i--) begin
      errs  = errs + EW'(DATA[i] ^ h_nxt[6] ^ h_nxt[5]);
      h_nxt = {h_nxt[5:0], DATA[i]};
      if (fill_nxt != 3'd7) fill_nxt = fill_nxt + 3'd1;
    end
  end

  assign checkable = (fill == 3'd7);
  assign word_err  = (errs != '0);
  assign err_sum   = {1'b0, err_cnt} + 65'(errs);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_HUNT;
      h        <= '0;
      fill     <= '0;
      g        <= '0;
      u        <= '0;
      recv_cnt <= '0;
      err_cnt  <= '0;
    end else if (CLR) begin
      state    <= ST_HUNT;
      h        <= '0;
      fill     <= '0;
      g        <= '0;
      u        <= '0;
      recv_cnt <= '0;
      err_cnt  <= '0;
    end else if (VALID) begin
      h    <= h_nxt;
      fill <= fill_nxt;
      case (state)
        ST_HUNT: begin
          if (checkable) begin
            if (word_err) begin
              g <= '0;
            end else if (g == G_LAST) begin
              g     <= '0;
              state <= ST_LOCKED;
            end else begin
              g <= g + 8'd1;
            end
          end
        end
        ST_LOCKED: begin
          // The word that drops lock is still counted.
          if (recv_cnt != '1) recv_cnt <= recv_cnt + 58'd1;
          err_cnt <= err_sum[64] ? '1 : err_sum[63:0];
          if (!word_err) begin
            u <= '0;
          end else if (u == U_LAST) begin
            u     <= '0;
            state <= ST_HUNT;
          end else begin
            u <= u + 8'd1;
          end
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

  assign LOCKED   = (state == ST_LOCKED);
  assign RECV_CNT = recv_cnt;
  assign ERR_CNT  = err_cnt;

endmodule
